fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch unit sitting directly upstream of the main controller. Holds the program counter, fetches each instruction from instruction memory over a request/acknowledge handshake, presents the instruction (and its decoded opcode/funct fields) to the controller, and on instruction commit computes the next PC from the controller's NPCSel selection. Provides a halt-on-misaligned-target check and a retired-instruction counter.

## Interface
- PC_RESET, 32'h0000_3000, PC value loaded on reset (must be word-aligned)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- im_req  out  1  instruction memory read request
- im_addr  out  32  instruction memory byte address (equals pc)
- im_ack  in  1  memory has valid data on im_rdata this cycle
- im_rdata  in  32  instruction word from memory
- instr  out  32  held instruction register
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- instr_valid  out  1  instr holds the instruction at pc, awaiting commit
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4 (return address for jal)
- commit  in  1  datapath finished current instruction; NPCSel and reg_target valid
- NPCSel  in  2  next-PC select from controller: 00 PC+4, 01 BEQ_JMP, 10 J_JMP, 11 REG_JMP
- reg_target  in  32  GPR[rs] value, used for REG_JMP
- halted  out  1  sticky; fetch stopped on misaligned target
- retired  out  32  count of committed instructions

## Operation
- States: IDLE, REQ, EXEC, HALT. Reset enters IDLE.
- IDLE: unconditionally -> REQ next cycle.
- REQ: im_req=1, im_addr=pc. When im_ack=1: instr <= im_rdata, -> EXEC. im_ack=0: stay, request held stable.
- EXEC: instr_valid=1. When commit=1: retired <= retired+1 (wraps 2^32-1 -> 0); pc <= npc; if npc[1:0]!=0 -> HALT, else -> REQ.
- HALT: halted=1, im_req=0, instr_valid=0; leaves only via rst_n.
- npc by NPCSel, all arithmetic modulo 2^32:
  - 00: pc + 4
  - 01: pc + 4 + (sign_extend(instr[15:0]) << 2)
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 11: reg_target
- Only REG_JMP can produce a misaligned npc; check applies to all selections anyway. On halt, pc holds the misaligned npc for debug.
- im_ack outside REQ ignored; commit outside EXEC ignored. im_ack and commit never act in the same cycle (mutually exclusive states).
- opcode, funct, pc_plus4 are combinational from instr/pc.

## Timing
- Reset (async assert): pc=im_addr=PC_RESET, pc_plus4=PC_RESET+4, instr=0, opcode=0, funct=0, instr_valid=0, im_req=0, halted=0, retired=0, state IDLE.
- im_req, instr_valid, halted are Moore outputs of state (registered, glitch-free).
- First im_req asserted 1 cycle after first rising edge with rst_n high.
- im_ack sampled at edge N -> instr_valid=1 from cycle N+1.
- commit sampled at edge M -> im_req=1 with new im_addr from cycle M+1 (or halted=1 from M+1).
- Minimum throughput: 2 cycles/instruction (zero-wait memory, commit in first EXEC cycle).
- rst_n asserted mid-REQ or mid-EXEC: outstanding request dropped immediately; memory must tolerate abandoned request.

## Test plan
- Reset release, zero-wait memory, im_rdata=32'h0000_0000 (nop), commit each EXEC with NPCSel=00 -> im_addr sequence 3000, 3004, 3008; retired=3 after third commit.
- Memory with 3-cycle ack latency -> im_req held high and im_addr stable 3 cycles; instr_valid rises cycle after ack.
- pc=3010, instr=beq with imm 16'hFFFC, NPCSel=01 -> next im_addr=3004; imm 16'h0002, NPCSel=01 -> 301C.
- pc=3000, instr=32'h0800_1000 (j), NPCSel=10 -> im_addr=0000_4000; pc_plus4=3004 during EXEC.
- NPCSel=11, reg_target=3102 -> halted=1 next cycle, pc=3102, im_req stays 0; reset restores pc=3000, halted=0.
- rst_n pulsed low during REQ wait and during EXEC -> outputs immediately at reset values; im_ack and commit pulses in wrong states produce no change.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, IM request/ack handshake, instruction hold, next-PC select.
// Fetch waits on im_ack for as long as memory needs; 2 cycles/instr minimum.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic [1:0]  NPCSel,
  input  logic [31:0] reg_target,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, REQ, EXEC, HALT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] npc;
  logic        take_ack;
  logic        take_commit;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = pc;

  assign take_ack    = (state == REQ)  && im_ack;
  assign take_commit = (state == EXEC) && commit;

  always_comb begin
    npc = pc_plus4;
    case (NPCSel)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      2'b10: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: npc = reg_target;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (im_ack) state_nxt = EXEC;
      EXEC: if (commit) state_nxt = (npc[1:0] != 2'b00) ? HALT : REQ;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they come straight off registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      im_req      <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      im_req      <= (state_nxt == REQ);
      instr_valid <= (state_nxt == EXEC);
      halted      <= (state_nxt == HALT);
    end
  end

  // On a misaligned target pc still takes npc so the faulting address is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= PC_RESET;
      instr   <= 32'd0;
      retired <= 32'd0;
    end else begin
      if (take_ack) begin
        instr <= im_rdata;
      end
      if (take_commit) begin
        pc      <= npc;
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses / halt events,
// a negedge monitor pops and compares them as the DUT raises im_req or halted.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        commit;
  logic [1:0]  NPCSel;
  logic [31:0] reg_target;
  logic        halted;
  logic [31:0] retired;

  typedef struct packed {
    logic        halt;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_RESET(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .funct      (funct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .commit     (commit),
    .NPCSel     (NPCSel),
    .reg_target (reg_target),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no response within 50 cycles, required one", name);
  endtask

  // Monitor: one event per im_req rising edge or halted rising edge.
  initial begin
    exp_t        e;
    logic        prev_req;
    logic        prev_halt;
    logic [31:0] prev_addr;
    prev_req  = 1'b0;
    prev_halt = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (im_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_req: got request at %h, required none", im_addr);
          end else begin
            e = exp_q.pop_front();
            check("req_event", {1'b0, im_addr}, e);
          end
        end else if (im_req && prev_req) begin
          check("addr_stable", {1'b0, im_addr}, {1'b0, prev_addr});
        end
        if (halted && !prev_halt) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_halt: got halt at pc %h, required none", pc);
          end else begin
            e = exp_q.pop_front();
            check("halt_event", {1'b1, pc}, e);
          end
        end
      end
      prev_req  = im_req;
      prev_halt = halted;
      prev_addr = im_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, required earlier finish");
    $fatal(1, "watchdog");
  end

  // Asserts reset for a full cycle, checks async reset values, releases; returns at posedge+1.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_im_req", im_req, 0);
    check("rst_im_addr", im_addr, 32'h3000);
    check("rst_pc", pc, 32'h3000);
    check("rst_pc_plus4", pc_plus4, 32'h3004);
    check("rst_instr", instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_funct", funct, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    @(posedge clk);
    #2;
    exp_q.push_back({1'b0, 32'h0000_3000});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_req", im_req, 1);
  endtask

  task automatic fetch(input logic [31:0] data, input int lat);
    int k;
    k = 0;
    while (!im_req && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!im_req) timeout("fetch_wait_req");
    repeat (lat) begin
      @(posedge clk); #1;
    end
    im_ack   = 1'b1;
    im_rdata = data;
    @(posedge clk); #1;
    im_ack   = 1'b0;
    im_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic execute(input logic [1:0] sel, input logic [31:0] tgt,
                         input logic h, input logic [31:0] exp_addr);
    int k;
    k = 0;
    while (!instr_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!instr_valid) timeout("exec_wait_valid");
    exp_q.push_back({h, exp_addr});
    commit     = 1'b1;
    NPCSel     = sel;
    reg_target = tgt;
    @(posedge clk); #1;
    commit     = 1'b0;
    NPCSel     = 2'b00;
    reg_target = 32'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    im_ack     = 1'b0;
    im_rdata   = 32'd0;
    commit     = 1'b0;
    NPCSel     = 2'b00;
    reg_target = 32'd0;

    do_reset();

    // Sequential nops, zero-wait memory.
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0000_0000, 0);
      execute(2'b00, 32'd0, 1'b0, 32'h3004 + 32'(4 * i));
    end
    check("retired_3", retired, 3);

    // Three-cycle memory latency at 300C.
    for (int i = 0; i < 3; i++) begin
      check("wait_req", im_req, 1);
      check("wait_addr", im_addr, 32'h300C);
      check("wait_valid", instr_valid, 0);
      @(posedge clk); #1;
    end
    im_ack   = 1'b1;
    im_rdata = 32'h0000_0000;
    check("valid_before_ack_edge", instr_valid, 0);
    @(posedge clk); #1;
    im_ack   = 1'b0;
    check("valid_after_ack", instr_valid, 1);
    check("req_after_ack", im_req, 0);
    execute(2'b00, 32'd0, 1'b0, 32'h3010);

    // Branches: 3010 -16 -> 3004, 3004 +8 -> 3010, 3010 +8 -> 301C.
    fetch(32'h1000_FFFC, 0);
    check("beq_opcode", opcode, 6'h04);
    execute(2'b01, 32'd0, 1'b0, 32'h3004);
    fetch(32'h1000_0002, 0);
    execute(2'b01, 32'd0, 1'b0, 32'h3010);
    fetch(32'h1000_0002, 0);
    execute(2'b01, 32'd0, 1'b0, 32'h301C);

    // Aligned register jump back to 3000, then j.
    fetch(32'h0000_0000, 0);
    execute(2'b11, 32'h0000_3000, 1'b0, 32'h3000);
    fetch(32'h0800_1000, 0);
    check("j_pc", pc, 32'h3000);
    check("j_pc_plus4", pc_plus4, 32'h3004);
    check("j_opcode", opcode, 6'h02);
    check("j_instr", instr, 32'h0800_1000);
    execute(2'b10, 32'd0, 1'b0, 32'h0000_4000);

    // Misaligned register jump halts.
    fetch(32'h03E0_0008, 0);
    check("jr_funct", funct, 6'h08);
    execute(2'b11, 32'h0000_3102, 1'b1, 32'h3102);
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 32'h3102);
    check("halt_req", im_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_retired", retired, 10);
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; im_ack = 1'b1; NPCSel = 2'b00;
      @(posedge clk); #1;
      commit = 1'b0; im_ack = 1'b0;
    end
    check("halt_sticky", halted, 1);
    check("halt_req_still0", im_req, 0);
    check("halt_pc_held", pc, 32'h3102);
    check("halt_retired_held", retired, 10);

    do_reset();

    // commit while waiting in REQ is ignored.
    commit = 1'b1; NPCSel = 2'b11; reg_target = 32'h0000_0005;
    @(posedge clk); #1;
    commit = 1'b0; NPCSel = 2'b00; reg_target = 32'd0;
    check("req_commit_pc", pc, 32'h3000);
    check("req_commit_retired", retired, 0);
    check("req_commit_req", im_req, 1);

    do_reset();   // mid-REQ

    fetch(32'hABCD_1234, 0);
    im_ack = 1'b1; im_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    im_ack = 1'b0;
    check("exec_ack_instr", instr, 32'hABCD_1234);
    check("exec_ack_valid", instr_valid, 1);

    do_reset();   // mid-EXEC

    fetch(32'h0000_0000, 0);
    execute(2'b00, 32'd0, 1'b0, 32'h3004);
    check("final_retired", retired, 1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 33'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
